// File: rtl/ldext_unit.sv
// ldext_unit: RISC-V load align/extend stage with a 2-entry output/skid buffer.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_word/in_offs/in_op
// carry one load beat; out_valid/out_ready/out_data/out_err return the result.
// Define LDEXT_MISALIGN_CHECK_EN to flag misaligned beats as errors; otherwise
// the offset bits below the op size are ignored.
module ldext_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int OFFS_WIDTH = $clog2(DATA_WIDTH/8)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_word,
    input  logic [OFFS_WIDTH-1:0] in_offs,
    input  logic [2:0]            in_op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_err
);
    logic [1:0]            lg;
    logic [6:0]            nbits;
    logic [OFFS_WIDTH-1:0] alm, offs_e;
    logic [DATA_WIDTH-1:0] sh, mask, res, data_c;
    logic                  illegal, sgn, err_c, accept;
    logic                  out_valid_q, out_valid_d, out_err_q, out_err_d;
    logic                  skid_full_q, skid_full_d, skid_err_q, skid_err_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
`ifdef LDEXT_MISALIGN_CHECK_EN
    logic                  misal;
`endif
    always_comb begin
        lg      = in_op[1:0];
        nbits   = 7'd8 << lg;
        alm     = OFFS_WIDTH'((4'd1 << lg) - 4'd1);
        illegal = in_op == 3'b111 || (DATA_WIDTH == 32 && (in_op == 3'b011 || in_op == 3'b110));
`ifdef LDEXT_MISALIGN_CHECK_EN
        misal   = |(in_offs & alm);
        offs_e  = in_offs;
        err_c   = illegal || misal;
`else
        offs_e  = in_offs & ~alm;
        err_c   = illegal;
`endif
        sh      = in_word >> {offs_e, 3'b000};
        mask    = lg == 2'd3 ? '1 : (DATA_WIDTH'(1) << nbits) - DATA_WIDTH'(1);
        // field MSB is the top set bit of the mask; unsigned ops never extend
        sgn     = !in_op[2] && |(sh & mask & ~(mask >> 1));
        res     = (sh & mask) | (sgn ? ~mask : '0);
        data_c  = err_c ? '0 : res;
    end
    assign in_ready  = !skid_full_q && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        skid_full_d = skid_full_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        if (!out_valid_q || out_ready) begin
            // output free: skid entry (older) wins; a full skid blocks new beats
            out_valid_d = skid_full_q || accept;
            out_data_d  = skid_full_q ? skid_data_q : accept ? data_c : out_data_q;
            out_err_d   = skid_full_q ? skid_err_q : accept ? err_c : out_err_q;
            skid_full_d = 1'b0;
        end else if (accept) begin
            skid_full_d = 1'b1;
            skid_data_d = data_c;
            skid_err_d  = err_c;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            skid_full_q <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            skid_full_q <= skid_full_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
        end
    end
endmodule

// File: tb/tb_ldext_unit.sv
// tb_ldext_unit: random and directed checks of 32- and 64-bit ldext_unit against a load model.
module tb_ldext_unit;
    logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic [63:0] w = 0;
    logic [2:0]  op = 0, offs = 0;
    logic        rdy32, ov32, err32, rdy64, ov64, err64;
    logic [31:0] d32;
    logic [63:0] d64;
    int          checks = 0, errors = 0, acc;
    logic        prev_rst = 0;
    typedef struct {logic err; logic [63:0] d;} res_t;
    res_t q32[$], q64[$];
    always #5 clk = ~clk;
    ldext_unit #(.DATA_WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .in_word(w[31:0]),
        .in_offs(offs[1:0]), .in_op(op), .out_valid(ov32), .out_ready(out_ready),
        .out_data(d32), .out_err(err32));
    ldext_unit #(.DATA_WIDTH(64)) u64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64), .in_word(w),
        .in_offs(offs), .in_op(op), .out_valid(ov64), .out_ready(out_ready),
        .out_data(d64), .out_err(err64));
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic res_t model(input logic [63:0] wd, input int o, input logic [2:0] f3, input int dw);
        res_t r;
        int sz = 1;
        logic sg = 0, ok = 1;
        logic [63:0] v;
        case (f3)
            3'd0: begin sz = 1; sg = 1; end
            3'd1: begin sz = 2; sg = 1; end
            3'd2: begin sz = 4; sg = 1; end
            3'd3: begin sz = 8; ok = dw == 64; end
            3'd4: sz = 1;
            3'd5: sz = 2;
            3'd6: begin sz = 4; ok = dw == 64; end
            default: ok = 0;
        endcase
        r.err = 1;
        r.d = 0;
        if (!ok) return r;
`ifdef LDEXT_MISALIGN_CHECK_EN
        if (o % sz != 0) return r;
`else
        o = o - o % sz;
`endif
        if (dw == 32) wd = wd & 64'hFFFF_FFFF;
        v = wd >> (8 * o);
        if (sz < 8) begin
            v = v % (64'd1 << (8 * sz));
            if (sg && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
        end
        if (dw == 32) v = v & 64'hFFFF_FFFF;
        r.err = 0;
        r.d = v;
        return r;
    endfunction
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_rdy32", 64'(rdy32), 64'd0);
            chk("rst_rdy64", 64'(rdy64), 64'd0);
            if (prev_rst) begin
                chk("rst_ov32", {31'd0, ov32, d32}, 64'd0);
                chk("rst_err32", 64'(err32), 64'd0);
                chk("rst_ov64", 64'(ov64), 64'd0);
                chk("rst_d64", d64, 64'd0);
                chk("rst_err64", 64'(err64), 64'd0);
            end
            q32.delete();
            q64.delete();
        end else begin
            chk("ov32", 64'(ov32), 64'(q32.size() > 0));
            chk("rdy32", 64'(rdy32), 64'(q32.size() < 2));
            if (ov32 && q32.size() > 0) begin
                chk("d32", 64'(d32), q32[0].d);
                chk("err32", 64'(err32), 64'(q32[0].err));
            end
            if (ov32 && out_ready && q32.size() > 0) void'(q32.pop_front());
            if (in_valid && rdy32) q32.push_back(model(w, int'(offs[1:0]), op, 32));
            chk("ov64", 64'(ov64), 64'(q64.size() > 0));
            chk("rdy64", 64'(rdy64), 64'(q64.size() < 2));
            if (ov64 && q64.size() > 0) begin
                chk("d64", d64, q64[0].d);
                chk("err64", 64'(err64), 64'(q64[0].err));
            end
            if (ov64 && out_ready && q64.size() > 0) void'(q64.pop_front());
            if (in_valid && rdy64) q64.push_back(model(w, int'(offs), op, 64));
        end
        prev_rst = rst;
    end
    task automatic send(input logic [63:0] wd, input logic [2:0] o, input logic [2:0] f3);
        w = wd;
        offs = o;
        op = f3;
        in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        out_ready = 1;
        #1 chk("rdy_after_rst", 64'(rdy32), 64'd1);
        send(64'h80F17F01, 3'd2, 3'b000);
        chk("lb_d", 64'(d32), 64'hFFFFFFF1);
        chk("lb_err", 64'(err32), 64'd0);
        send(64'h80F17F01, 3'd2, 3'b101);
        chk("lhu_d", 64'(d32), 64'h000080F1);
        send(64'h80F17F01, 3'd2, 3'b001);
        chk("lh_d", 64'(d32), 64'hFFFF80F1);
        send(64'h80F17F01, 3'd1, 3'b010);
`ifdef LDEXT_MISALIGN_CHECK_EN
        chk("lw_mis_d", {31'd0, err32, d32}, 64'h1_0000_0000);
`else
        chk("lw_mis_d", {31'd0, err32, d32}, 64'h0_80F1_7F01);
`endif
        send(64'h8000000012345678, 3'd4, 3'b110);
        chk("lwu64_d", d64, 64'h0000000080000000);
        chk("lwu64_err", 64'(err64), 64'd0);
        send(64'h8000000012345678, 3'd0, 3'b111);
        chk("ill64_err", 64'(err64), 64'd1);
        chk("ill64_d", d64, 64'd0);
        @(posedge clk);
        #1 out_ready = 0;
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            w = {$urandom, $urandom};
            offs = 3'($urandom);
            op = 3'($urandom);
            in_valid = 1;
            #3 if (rdy32) acc++;
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        chk("stall_acc", 64'(acc), 64'd2);
        chk("stall_rdy", 64'(rdy32), 64'd0);
        out_ready = 1;
        @(posedge clk);
        #1 chk("drain1_rdy", 64'(rdy32), 64'd1);
        chk("drain1_ov", 64'(ov32), 64'd1);
        @(posedge clk);
        #1 chk("drain2_ov", 64'(ov32), 64'd0);
        out_ready = 0;
        send(64'h1111_2222_3333_4444, 3'd0, 3'b011);
        send(64'h5555_6666_7777_8888, 3'd0, 3'b010);
        chk("full_rdy", 64'(rdy32), 64'd0);
        rst = 1;
        @(posedge clk);
        #1 chk("rstfull_ov", 64'(ov32), 64'd0);
        chk("rstfull_rdy", 64'(rdy32), 64'd0);
        rst = 0;
        #1 chk("rstfull_rdy_after", 64'(rdy32), 64'd1);
        out_ready = 1;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 3000; i++) begin
            #1;
            in_valid = ($urandom % 4) != 0;
            out_ready = (i / 50) % 3 == 0 ? 1'b1 : (i / 50) % 3 == 1 ? 1'($urandom) : ($urandom % 5) == 0;
            w = {$urandom, $urandom};
            offs = 3'($urandom);
            op = 3'($urandom);
            rst = ($urandom % 200) == 0 || (rst && ($urandom % 2) == 0);
            @(posedge clk);
        end
        #1 rst = 0;
        in_valid = 0;
        out_ready = 1;
        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
